// File: rtl/dsp_mul_accum_pkg.sv
// rtl/dsp_mul_accum_pkg.sv - shared state type and default widths for the frame accumulator
package dsp_mul_accum_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

   localparam int P_WIDTH_DEF   = 38;
   localparam int ACC_WIDTH_DEF = 48;
   localparam int LEN_WIDTH_DEF = 8;

endpackage

// File: rtl/dsp_mul_accum_frame.sv
// rtl/dsp_mul_accum_frame.sv - accumulates frame_len unsigned products per frame
// and presents the registered frame sum with a sticky per-frame overflow flag.
module dsp_mul_accum_frame
   import dsp_mul_accum_pkg::*;
#(
   parameter int P_WIDTH   = P_WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [P_WIDTH-1:0]   in_p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [LEN_WIDTH-1:0] out_count,
   output logic                 out_overflow
);

   acc_state_t           state;
   logic [ACC_WIDTH-1:0] acc;
   logic [LEN_WIDTH-1:0] count;
   logic [LEN_WIDTH-1:0] len_q;
   logic                 ovf;

   logic                 accept;
   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH:0]   sum;
   logic [LEN_WIDTH-1:0] eff_len;
   logic [LEN_WIDTH-1:0] count_nxt;

   // in_ready depends on the state register only, never on the handshake inputs
   assign in_ready  = (state != HOLD);
   assign accept    = in_valid & in_ready & ~clear;
   assign p_ext     = ACC_WIDTH'(in_p);
   assign sum       = {1'b0, acc} + {1'b0, p_ext};
   assign eff_len   = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
   assign count_nxt = count + LEN_WIDTH'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         len_q        <= '0;
         ovf          <= 1'b0;
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else if (clear) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         ovf          <= 1'b0;
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  len_q <= eff_len;
                  acc   <= p_ext;
                  count <= LEN_WIDTH'(1);
                  ovf   <= 1'b0;
                  if (eff_len == LEN_WIDTH'(1)) begin
                     state        <= HOLD;
                     out_valid    <= 1'b1;
                     out_acc      <= p_ext;
                     out_count    <= LEN_WIDTH'(1);
                     out_overflow <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= sum[ACC_WIDTH-1:0];
                  ovf   <= ovf | sum[ACC_WIDTH];
                  count <= count_nxt;
                  if (count_nxt == len_q) begin
                     state        <= HOLD;
                     out_valid    <= 1'b1;
                     out_acc      <= sum[ACC_WIDTH-1:0];
                     out_count    <= count_nxt;
                     out_overflow <= ovf | sum[ACC_WIDTH];
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_mul_accum_frame.sv
// tb/tb_dsp_mul_accum_frame.sv - scoreboard bench for dsp_mul_accum_frame
// Two instances (48-bit and 40-bit accumulators) share one stimulus stream.
module tb_dsp_mul_accum_frame;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [7:0]  frame_len;
   logic        in_valid;
   logic [37:0] in_p;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_overflow_a;
   logic [47:0] out_acc_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_overflow_b;
   logic [39:0] out_acc_b;
   logic [7:0]  out_count_b;

   typedef struct {
      logic [47:0] acc48;
      logic [39:0] acc40;
      logic [7:0]  cnt;
      logic        ovf48;
      logic        ovf40;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   localparam logic [37:0] PMAX = 38'd274876596225;

   dsp_mul_accum_frame #(.P_WIDTH(38), .ACC_WIDTH(48), .LEN_WIDTH(8)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .frame_len(frame_len),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_p(in_p),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
      .out_count(out_count_a), .out_overflow(out_overflow_a)
   );

   dsp_mul_accum_frame #(.P_WIDTH(38), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .frame_len(frame_len),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_p(in_p),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
      .out_count(out_count_b), .out_overflow(out_overflow_b)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] len0, input logic [7:0] len1,
                              input logic [37:0] ps[$], input int n_beats, input int gap);
      int          eff;
      exp_t        e;
      logic [48:0] t48;
      logic [40:0] t40;
      eff     = (len0 == 8'd0) ? 1 : int'(len0);
      e.acc48 = '0;
      e.acc40 = '0;
      e.ovf48 = 1'b0;
      e.ovf40 = 1'b0;
      e.cnt   = 8'(eff);
      for (int i = 0; i < ps.size(); i++) begin
         t48 = {1'b0, e.acc48} + 49'(ps[i]);
         t40 = {1'b0, e.acc40} + 41'(ps[i]);
         e.ovf48 = e.ovf48 | t48[48];
         e.ovf40 = e.ovf40 | t40[40];
         e.acc48 = t48[47:0];
         e.acc40 = t40[39:0];
      end
      if (n_beats == eff) sb.push_back(e);
      for (int i = 0; i < n_beats; i++) begin
         frame_len = (i == 0) ? len0 : len1;
         in_p      = ps[i];
         in_valid  = 1'b1;
         checks++;
         if (in_ready_a !== 1'b1) $display("FAIL beat_ready: in_ready=%0b required 1", in_ready_a);
         else passed++;
         tick;
         in_valid = 1'b0;
         in_p     = '0;
         if (i < n_beats - 1) begin
            checks++;
            if (out_valid_a !== 1'b0) $display("FAIL early_valid: out_valid=%0b required 0", out_valid_a);
            else passed++;
            for (int g = 0; g < gap; g++) begin
               tick;
               checks++;
               if (in_ready_a !== 1'b1) $display("FAIL gap_ready: in_ready=%0b required 1", in_ready_a);
               else passed++;
            end
         end
      end
      if (n_beats == eff) begin
         checks++;
         if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1)
            $display("FAIL latency: out_valid a=%0b b=%0b required 1", out_valid_a, out_valid_b);
         else passed++;
      end
   endtask

   task automatic drain(input int stall);
      exp_t e;
      int   w;
      w = 0;
      while (out_valid_a !== 1'b1 && w < 20) begin
         tick;
         w++;
      end
      checks++;
      if (out_valid_a !== 1'b1) begin
         $display("FAIL result_timeout: out_valid=%0b required 1", out_valid_a);
         return;
      end else passed++;
      checks++;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard_empty: size=0 required >0");
         return;
      end else passed++;
      e = sb.pop_front();
      for (int s = 0; s < stall; s++) begin
         in_valid  = 1'b1;
         in_p      = PMAX;
         out_ready = 1'b0;
         tick;
         checks++;
         if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || out_acc_a !== e.acc48)
            $display("FAIL stall_hold: valid=%0b ready=%0b acc=%0d required 1 0 %0d",
                     out_valid_a, in_ready_a, out_acc_a, e.acc48);
         else passed++;
      end
      checks++;
      if (out_acc_a !== e.acc48) $display("FAIL acc48: got %0d required %0d", out_acc_a, e.acc48);
      else passed++;
      checks++;
      if (out_count_a !== e.cnt) $display("FAIL count48: got %0d required %0d", out_count_a, e.cnt);
      else passed++;
      checks++;
      if (out_overflow_a !== e.ovf48) $display("FAIL ovf48: got %0b required %0b", out_overflow_a, e.ovf48);
      else passed++;
      checks++;
      if (out_acc_b !== e.acc40) $display("FAIL acc40: got %0d required %0d", out_acc_b, e.acc40);
      else passed++;
      checks++;
      if (out_count_b !== e.cnt) $display("FAIL count40: got %0d required %0d", out_count_b, e.cnt);
      else passed++;
      checks++;
      if (out_overflow_b !== e.ovf40) $display("FAIL ovf40: got %0b required %0b", out_overflow_b, e.ovf40);
      else passed++;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_p      = '0;
      checks++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
         $display("FAIL after_take: valid=%0b ready=%0b required 0 1", out_valid_a, in_ready_a);
      else passed++;
   endtask

   task automatic test_reset;
      reset = 1'b1; clear = 1'b0; frame_len = 8'd1; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
      tick;
      tick;
      reset = 1'b0;
      tick;
      checks++;
      if (out_valid_a !== 1'b0 || out_acc_a !== 48'd0 || out_count_a !== 8'd0 ||
          out_overflow_a !== 1'b0 || in_ready_a !== 1'b1)
         $display("FAIL reset_state: valid=%0b acc=%0d cnt=%0d ovf=%0b ready=%0b required 0 0 0 0 1",
                  out_valid_a, out_acc_a, out_count_a, out_overflow_a, in_ready_a);
      else passed++;
   endtask

   task automatic test_single_beat;
      logic [37:0] ps[$];
      ps.push_back(38'd10);
      drive_frame(8'd1, 8'd1, ps, 1, 0);
      drain(0);
   endtask

   task automatic test_gapped_frame;
      logic [37:0] ps[$];
      ps.push_back(38'd10); ps.push_back(38'd6); ps.push_back(38'd0); ps.push_back(PMAX);
      drive_frame(8'd4, 8'd4, ps, 4, 2);
      checks++;
      if (out_acc_a !== 48'd274876596241) $display("FAIL gapped_sum: got %0d required 274876596241", out_acc_a);
      else passed++;
      drain(0);
   endtask

   task automatic test_backpressure;
      logic [37:0] ps[$];
      ps.push_back(38'd100); ps.push_back(38'd200);
      drive_frame(8'd2, 8'd2, ps, 2, 0);
      drain(5);
   endtask

   task automatic test_overflow;
      logic [37:0] ps[$];
      for (int i = 0; i < 5; i++) ps.push_back(PMAX);
      drive_frame(8'd5, 8'd5, ps, 5, 0);
      checks++;
      if (out_acc_b !== 40'd274871353349 || out_overflow_b !== 1'b1)
         $display("FAIL ovf_frame: acc=%0d ovf=%0b required 274871353349 1", out_acc_b, out_overflow_b);
      else passed++;
      drain(0);
      ps.delete();
      for (int i = 0; i < 4; i++) ps.push_back(PMAX);
      drive_frame(8'd4, 8'd4, ps, 4, 0);
      checks++;
      if (out_acc_b !== 40'd1099506384900 || out_overflow_b !== 1'b0)
         $display("FAIL ovf_cleared: acc=%0d ovf=%0b required 1099506384900 0", out_acc_b, out_overflow_b);
      else passed++;
      drain(0);
   endtask

   task automatic test_len_edge;
      logic [37:0] ps[$];
      ps.push_back(38'd7);
      drive_frame(8'd0, 8'd0, ps, 1, 0);
      drain(0);
      ps.delete();
      ps.push_back(38'd1); ps.push_back(38'd2); ps.push_back(38'd3);
      drive_frame(8'd3, 8'd1, ps, 3, 1);
      drain(0);
   endtask

   task automatic test_clear;
      logic [37:0] ps[$];
      ps.push_back(38'd1); ps.push_back(38'd2);
      drive_frame(8'd4, 8'd4, ps, 2, 0);
      clear = 1'b1; in_valid = 1'b1; in_p = 38'd99; frame_len = 8'd1;
      tick;
      clear = 1'b0; in_valid = 1'b0; in_p = '0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid_a !== 1'b0 || out_acc_a !== 48'd0 || in_ready_a !== 1'b1)
            $display("FAIL clear_idle: valid=%0b acc=%0d ready=%0b required 0 0 1", out_valid_a, out_acc_a, in_ready_a);
         else passed++;
         tick;
      end
      ps.delete();
      ps.push_back(38'd3); ps.push_back(38'd4);
      drive_frame(8'd2, 8'd2, ps, 2, 0);
      checks++;
      if (out_acc_a !== 48'd7) $display("FAIL clear_next: got %0d required 7", out_acc_a);
      else passed++;
      drain(0);
   endtask

   task automatic test_back_to_back;
      logic [37:0] ps[$];
      for (int f = 1; f <= 3; f++) begin
         ps.delete();
         ps.push_back(38'(f * 11));
         ps.push_back(38'(f * 13));
         drive_frame(8'd2, 8'd2, ps, 2, 0);
         drain(0);
      end
   endtask

   task automatic test_reset_in_hold;
      logic [37:0] ps[$];
      exp_t        dropped;
      ps.push_back(38'd10);
      drive_frame(8'd1, 8'd1, ps, 1, 0);
      if (sb.size() > 0) dropped = sb.pop_front();
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_acc_a !== 48'd0 || out_count_a !== 8'd0 ||
          out_overflow_a !== 1'b0 || in_ready_a !== 1'b1)
         $display("FAIL async_reset: valid=%0b acc=%0d cnt=%0d ovf=%0b ready=%0b required 0 0 0 0 1",
                  out_valid_a, out_acc_a, out_count_a, out_overflow_a, in_ready_a);
      else passed++;
      tick;
      reset = 1'b0;
      tick;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single_beat;
      test_gapped_frame;
      test_backpressure;
      test_overflow;
      test_len_edge;
      test_clear;
      test_back_to_back;
      test_reset_in_hold;
      checks++;
      if (sb.size() != 0) $display("FAIL scoreboard_leftover: size=%0d required 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
